// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  // Byte depth of the attached data memory when the top is not overridden.
  localparam int unsigned MEM_BYTES_DEFAULT = 32'd32;

  // Access sequencer states: accept a request, strobe memory, return result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Requester identity; also used as the round-robin priority pointer.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // After a grant, priority moves to whoever did not win.
  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin decision: a lone requester always wins, a tie goes to
// the requester named by the priority pointer. Grants only while advance_i.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,      // bit 0 = A, bit 1 = B
  input  logic       ptr_i,      // priority holder on a tie (0 = A, 1 = B)
  input  logic       advance_i,  // arbitration window open
  output logic [1:0] grant_o     // one-hot grant, zero when no window
);

  // Resolve the grant from the request pair and the priority pointer.
  always_comb begin
    grant_o = 2'b00;
    if (advance_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (ptr_i == REQ_B) ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end else begin
      grant_o = 2'b00;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one registered-read data memory between
// requester A (CPU load/store) and requester B (debug/DMA). Each access runs
// IDLE -> ISSUE -> RESP. Out-of-range accesses are flagged and never reach
// memory. Optional macro DMEM_ARB_ALIGN_CHK_EN also flags misaligned words.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 32'd32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [31:0]       a_wdata_i,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [31:0]       b_wdata_i,
  output logic              a_ack_o,
  output logic              b_ack_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_rdata_i
);

  state_e            state_q, state_d;
  req_id_e           ptr_q, ptr_d;
  req_id_e           id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bad_q, bad_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              err_q, err_d;

  logic [1:0]        grant_s;
  req_id_e           win_id_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [31:0]       win_wdata_s;
  logic [ADDR_W:0]   win_last_byte_s;
  logic              range_err_s;
  logic              align_err_s;

  rr_arb2 u_rr_arb2 (
    .req_i     ({b_req_i, a_req_i}),
    .ptr_i     (ptr_q),
    .advance_i (state_q == IDLE),
    .grant_o   (grant_s)
  );

  // Select the winning requester's operands for latching.
  always_comb begin
    win_id_s    = REQ_A;
    win_we_s    = a_we_i;
    win_addr_s  = a_addr_i;
    win_wdata_s = a_wdata_i;
    if (grant_s[1]) begin
      win_id_s    = REQ_B;
      win_we_s    = b_we_i;
      win_addr_s  = b_addr_i;
      win_wdata_s = b_wdata_i;
    end else begin
      win_id_s    = REQ_A;
      win_we_s    = a_we_i;
      win_addr_s  = a_addr_i;
      win_wdata_s = a_wdata_i;
    end
  end

  // The last byte of the word must fall inside the memory; one extra bit
  // keeps the sum from wrapping at the top of the address space.
  assign win_last_byte_s = {1'b0, win_addr_s} + (ADDR_W+1)'(3);
  assign range_err_s     = (win_last_byte_s >= (ADDR_W+1)'(MEM_BYTES));

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign align_err_s = (win_addr_s[1:0] != 2'b00);
`else
  assign align_err_s = 1'b0;
`endif

  // Next-state and next-output logic; strobes and acks are registered so
  // they line up exactly with the ISSUE and RESP cycles.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bad_d       = bad_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          id_d        = win_id_s;
          we_d        = win_we_s;
          addr_d      = win_addr_s;
          wdata_d     = win_wdata_s;
          bad_d       = range_err_s | align_err_s;
          ptr_d       = other_id(win_id_s);
          mem_read_d  = !win_we_s && !(range_err_s | align_err_s);
          mem_write_d = win_we_s && !(range_err_s | align_err_s);
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        a_ack_d = (id_q == REQ_A);
        b_ack_d = (id_q == REQ_B);
        err_d   = bad_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs; reset clears everything.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_A;
      id_q        <= REQ_A;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      bad_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bad_q       <= bad_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      err_q       <= err_d;
    end
  end

  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign err_o       = err_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Memory read data is registered by the memory and only valid in RESP,
  // so it is gated straight through during the ack of a good read.
  assign rdata_o = ((a_ack_q | b_ack_q) && !we_q && !err_q) ? mem_rdata_i : 32'h0000_0000;

endmodule
